// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
// The wait counter is fixed at 8 bits, which bounds TIMEOUT to 1..255.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_TIMEOUT    = 255;
    localparam int WAIT_CNT_WIDTH = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick. On a tie, the requester that was
// not granted last time wins.
module rr_pick2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_grant,
    output logic o_any
);

    assign o_any   = i_valid0 | i_valid1;
    assign o_grant = (i_valid0 & i_valid1) ? ~i_last : i_valid1;

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// One transaction is in flight at a time: IDLE picks, GRANT drives the port, RESP pulses ready.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic                  req0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_wdata,
    output logic                  req0_ready,
    output logic [WIDTH-1:0]      req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_wdata,
    output logic                  req1_ready,
    output logic [WIDTH-1:0]      req1_rdata,
    output logic                  req1_err,

    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_CNT = WAIT_CNT_WIDTH'(TIMEOUT);
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE     = WAIT_CNT_WIDTH'(1);

    // Per-requester views so the datapath can be indexed by the grant bit
    logic [1:0]            w_valid;
    logic [1:0]            w_wr_rd;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [WIDTH-1:0]      w_wdata [2];

    assign w_valid = {req1_valid, req0_valid};
    assign w_wr_rd = {req1_wr_rd, req0_wr_rd};
    assign w_addr[0]  = req0_addr;
    assign w_addr[1]  = req1_addr;
    assign w_wdata[0] = req0_wdata;
    assign w_wdata[1] = req1_wdata;

    state_t                    r_state, w_state_next;
    logic                      r_g, w_g_next;
    logic                      r_lg, w_lg_next;
    logic [WAIT_CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                      r_mem_valid, w_mem_valid_next;
    logic                      r_mem_wr_rd, w_mem_wr_rd_next;
    logic [ADDR_WIDTH-1:0]     r_mem_addr, w_mem_addr_next;
    logic [WIDTH-1:0]          r_mem_wdata, w_mem_wdata_next;
    logic [1:0]                r_ready, w_ready_next;
    logic [1:0]                r_err, w_err_next;
    logic [1:0][WIDTH-1:0]     r_rdata, w_rdata_next;

    logic                      w_pick;
    logic                      w_any;
    logic [WAIT_CNT_WIDTH-1:0] w_cnt_inc;

    rr_pick2 u_pick (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_lg),
        .o_grant  (w_pick),
        .o_any    (w_any)
    );

    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_comb begin
        w_state_next     = r_state;
        w_g_next         = r_g;
        w_lg_next        = r_lg;
        w_cnt_next       = r_cnt;
        w_mem_valid_next = r_mem_valid;
        w_mem_wr_rd_next = r_mem_wr_rd;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_ready_next     = r_ready;
        w_err_next       = r_err;
        w_rdata_next     = r_rdata;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_g_next         = w_pick;
                    w_lg_next        = w_pick;
                    w_cnt_next       = '0;
                    w_mem_valid_next = 1'b1;
                    w_mem_wr_rd_next = w_wr_rd[w_pick];
                    w_mem_addr_next  = w_addr[w_pick];
                    w_mem_wdata_next = w_wdata[w_pick];
                    w_state_next     = GRANT;
                end
            end
            GRANT: begin
                // A response arriving on the timeout cycle still counts as success
                if (mem_ready) begin
                    w_rdata_next[r_g] = mem_rdata;
                    w_err_next[r_g]   = 1'b0;
                    w_ready_next[r_g] = 1'b1;
                    w_mem_valid_next  = 1'b0;
                    w_state_next      = RESP;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_rdata_next[r_g] = '0;
                    w_err_next[r_g]   = 1'b1;
                    w_ready_next[r_g] = 1'b1;
                    w_mem_valid_next  = 1'b0;
                    w_state_next      = RESP;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            RESP: begin
                w_ready_next = 2'b00;
                w_err_next   = 2'b00;
                w_state_next = IDLE;
            end
            default: begin
                w_mem_valid_next = 1'b0;
                w_ready_next     = 2'b00;
                w_err_next       = 2'b00;
                w_state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_g         <= 1'b0;
            r_lg        <= 1'b1;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_wr_rd <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ready     <= 2'b00;
            r_err       <= 2'b00;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_g         <= w_g_next;
            r_lg        <= w_lg_next;
            r_cnt       <= w_cnt_next;
            r_mem_valid <= w_mem_valid_next;
            r_mem_wr_rd <= w_mem_wr_rd_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_ready     <= w_ready_next;
            r_err       <= w_err_next;
            r_rdata     <= w_rdata_next;
        end
    end

    assign mem_valid  = r_mem_valid;
    assign mem_wr_rd  = r_mem_wr_rd;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign req0_ready = r_ready[0];
    assign req1_ready = r_ready[1];
    assign req0_err   = r_err[0];
    assign req1_err   = r_err[1];
    assign req0_rdata = r_rdata[0];
    assign req1_rdata = r_rdata[1];

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_rr_arbiter;

    localparam int W  = 16;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_wr_rd = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [W-1:0]  req0_wdata = '0;
    logic          req0_ready, req0_err;
    logic [W-1:0]  req0_rdata;
    logic          req1_valid = 1'b0, req1_wr_rd = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [W-1:0]  req1_wdata = '0;
    logic          req1_ready, req1_err;
    logic [W-1:0]  req1_rdata;
    logic          mem_valid, mem_wr_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ready = 1'b0;
    logic [W-1:0]  mem_rdata = '0;

    mem_rr_arbiter #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr_rd(req0_wr_rd), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_wr_rd(req1_wr_rd), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mem_ready  = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_valid"}, 32'(mem_valid), 0);
        chk({tag, " mem_wr_rd"}, 32'(mem_wr_rd), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " ready"}, 32'({req1_ready, req0_ready}), 0);
        chk({tag, " err"}, 32'({req1_err, req0_err}), 0);
        chk({tag, " rdata0"}, 32'(req0_rdata), 0);
        chk({tag, " rdata1"}, 32'(req1_rdata), 0);
    endtask

    // Answer the memory request after dly cycles (dly > TO never answers),
    // then check the completion pulse on the granted requester.
    task automatic serve(input int dly, input logic [W-1:0] mrd, input bit g,
                         input logic [AW-1:0] exp_addr, input bit exp_err,
                         input bit chk_rd, input logic [W-1:0] exp_rd, input string tag);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < TO + 2) begin
            cyc++;
            mem_ready = (cyc == dly);
            mem_rdata = (cyc == dly) ? mrd : W'($urandom);
            step();
            if (req0_ready || req1_ready) got = 1'b1;
            else begin
                chk({tag, " addr held"}, 32'(mem_addr), 32'(exp_addr));
                chk({tag, " mem_valid held"}, 32'(mem_valid), 1);
            end
        end
        mem_ready = 1'b0;
        chk({tag, " ready seen"}, 32'(got), 1);
        chk({tag, " latency"}, 32'(cyc), 32'((dly < TO) ? dly : TO));
        chk({tag, " ready g"}, 32'(g ? req1_ready : req0_ready), 1);
        chk({tag, " ready other"}, 32'(g ? req0_ready : req1_ready), 0);
        chk({tag, " mem_valid in resp"}, 32'(mem_valid), 0);
        chk({tag, " err g"}, 32'(g ? req1_err : req0_err), 32'(exp_err));
        chk({tag, " err other"}, 32'(g ? req0_err : req1_err), 0);
        if (chk_rd) chk({tag, " rdata"}, 32'(g ? req1_rdata : req0_rdata), 32'(exp_rd));
        step();
        chk({tag, " single pulse"}, 32'({req1_ready, req0_ready}), 0);
    endtask

    typedef struct {
        bit            rst_first;
        bit            v0;
        bit            w0;
        logic [AW-1:0] a0;
        logic [W-1:0]  d0;
        bit            v1;
        bit            w1;
        logic [AW-1:0] a1;
        logic [W-1:0]  d1;
        int            dly;
        logic [W-1:0]  mrd;
        bit            g;
        bit            err;
        bit            chk_rd;
        logic [W-1:0]  rd;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input vec_t v, input int idx);
        string         tag;
        logic [AW-1:0] ea;
        tag = $sformatf("vec%0d", idx);
        if (v.rst_first) do_reset(2);
        req0_valid = v.v0; req0_wr_rd = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_wr_rd = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
        ea = v.g ? v.a1 : v.a0;
        step();
        chk({tag, " grant mem_valid"}, 32'(mem_valid), 1);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, " mem_wr_rd"}, 32'(mem_wr_rd), 32'(v.g ? v.w1 : v.w0));
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.g ? v.d1 : v.d0));
        serve(v.dly, v.mrd, v.g, ea, v.err, v.chk_rd, v.rd, tag);
        $display("vec%0d: grant=%0d addr=0x%0h err=%0d", idx, v.g, ea, v.err);
    endtask

    // Random-phase state: requesters, memory contents, in-flight transaction
    logic [W-1:0]  ref_mem [D];
    bit            rv [2];
    bit            rw [2];
    logic [AW-1:0] ra [2];
    logic [W-1:0]  rdd [2];
    bit            rhold [2];
    bit            rnew [2];

    initial begin
        bit            act, mlast, tg, twr, eg, exp_err;
        int            cnt, dly, due, waitc, ntxn;
        logic [AW-1:0] taddr;
        logic [W-1:0]  twd;

        //         rst v0 w0 a0     d0        v1 w1 a1     d1  dly mrd       g  err chk rd
        vecs[0]  = '{1, 1, 1, 6'h05, 16'hA5A5, 0, 0, 6'h00, 0,  1, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 1, 0, 6'h10, 16'h0000, 1, 0, 6'h20, 0,  2, 16'h1111, 0, 0, 1, 16'h1111};
        vecs[2]  = '{0, 0, 0, 6'h10, 16'h0000, 1, 0, 6'h20, 0,  1, 16'h2222, 1, 0, 1, 16'h2222};
        vecs[3]  = '{0, 1, 1, 6'h01, 16'h1001, 1, 0, 6'h21, 0,  1, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[4]  = '{0, 1, 1, 6'h02, 16'h1002, 1, 0, 6'h22, 0,  3, 16'h2002, 1, 0, 1, 16'h2002};
        vecs[5]  = '{0, 1, 1, 6'h03, 16'h1003, 1, 0, 6'h23, 0,  2, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[6]  = '{0, 1, 1, 6'h04, 16'h1004, 1, 0, 6'h24, 0,  4, 16'h2004, 1, 0, 1, 16'h2004};
        vecs[7]  = '{0, 1, 1, 6'h05, 16'h1005, 1, 0, 6'h25, 0,  1, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[8]  = '{0, 1, 1, 6'h06, 16'h1006, 1, 0, 6'h26, 0,  2, 16'h2006, 1, 0, 1, 16'h2006};
        vecs[9]  = '{0, 1, 0, 6'h07, 16'h0000, 0, 0, 6'h00, 0, 99, 16'h7777, 0, 1, 1, 16'h0000};
        vecs[10] = '{0, 0, 0, 6'h00, 16'h0000, 1, 0, 6'h2A, 0,  1, 16'hBEEF, 1, 0, 1, 16'hBEEF};

        do_reset(2);
        chk_reset_outputs("reset");
        $display("reset: outputs idle");

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset in the middle of GRANT aborts silently; req0 wins the first tie afterwards
        req0_valid = 1; req0_wr_rd = 0; req0_addr = 6'h11;
        req1_valid = 0;
        step();
        chk("abort grant", 32'(mem_valid), 1);
        mem_ready = 0;
        step();
        rst = 1;
        step();
        chk("abort mem_valid", 32'(mem_valid), 0);
        chk("abort no ready", 32'({req1_ready, req0_ready}), 0);
        chk_reset_outputs("abort");
        rst = 0;
        req1_valid = 1; req1_wr_rd = 0; req1_addr = 6'h22;
        step();
        chk("post-reset grant", 32'(mem_valid), 1);
        chk("post-reset addr", 32'(mem_addr), 32'h11);
        serve(1, 16'h1234, 0, 6'h11, 0, 1, 16'h1234, "post-reset");
        $display("abort: reset mid-grant, next grant req0");

        // Request fields changing mid-GRANT must not reach the memory port
        req0_valid = 0;
        req1_valid = 1; req1_wr_rd = 0; req1_addr = 6'h3F;
        step();
        chk("hold grant", 32'(mem_valid), 1);
        chk("hold addr start", 32'(mem_addr), 32'h3F);
        req1_addr = 6'h00;
        serve(3, 16'h0F0F, 1, 6'h3F, 0, 1, 16'h0F0F, "hold");
        req1_valid = 0;
        $display("hold: addr 0x3F kept while req1_addr changed");

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < D; i++) ref_mem[i] = W'($urandom);
        for (int r = 0; r < 2; r++) begin
            rv[r] = 0; rw[r] = 0; ra[r] = '0; rdd[r] = '0; rhold[r] = 0; rnew[r] = 0;
        end
        do_reset(2);
        act = 0; mlast = 1; tg = 0; twr = 0; taddr = '0; twd = '0;
        cnt = 0; dly = 0; due = 0; waitc = 0; ntxn = 0;
        for (int c = 0; c < 3000; c++) begin
            req0_valid = rv[0]; req0_wr_rd = rw[0]; req0_addr = ra[0]; req0_wdata = rdd[0];
            req1_valid = rv[1]; req1_wr_rd = rw[1]; req1_addr = ra[1]; req1_wdata = rdd[1];
            step();
            if (act) begin
                cnt++;
                if (cnt == due) begin
                    exp_err = (dly > TO);
                    chk("rnd ready g", 32'(tg ? req1_ready : req0_ready), 1);
                    chk("rnd ready other", 32'(tg ? req0_ready : req1_ready), 0);
                    chk("rnd mem_valid resp", 32'(mem_valid), 0);
                    chk("rnd err g", 32'(tg ? req1_err : req0_err), 32'(exp_err));
                    chk("rnd err other", 32'(tg ? req0_err : req1_err), 0);
                    if (exp_err)
                        chk("rnd rdata timeout", 32'(tg ? req1_rdata : req0_rdata), 0);
                    else if (!twr)
                        chk("rnd rdata", 32'(tg ? req1_rdata : req0_rdata), 32'(ref_mem[taddr]));
                    if (twr && !exp_err) ref_mem[taddr] = twd;
                    $display("rnd txn %0d: req%0d %s addr=0x%0h dly=%0d err=%0d",
                             ntxn, tg, twr ? "wr" : "rd", taddr, dly, exp_err);
                    ntxn++;
                    rhold[tg] = 1;
                    act = 0;
                end else begin
                    chk("rnd mem_valid wait", 32'(mem_valid), 1);
                    chk("rnd ready wait", 32'({req1_ready, req0_ready}), 0);
                    chk("rnd addr wait", 32'(mem_addr), 32'(taddr));
                end
            end else if (mem_valid) begin
                chk("rnd grant has request", 32'(rv[0] || rv[1]), 1);
                eg = (rv[0] && rv[1]) ? !mlast : rv[1];
                mlast = eg;
                chk("rnd grant addr", 32'(mem_addr), 32'(ra[eg]));
                chk("rnd grant wr_rd", 32'(mem_wr_rd), 32'(rw[eg]));
                chk("rnd grant wdata", 32'(mem_wdata), 32'(rdd[eg]));
                tg = eg; taddr = ra[eg]; twr = rw[eg]; twd = rdd[eg];
                act = 1; cnt = 0;
                dly = $urandom_range(1, TO + 2);
                due = (dly < TO) ? dly : TO;
                waitc = 0;
            end else begin
                chk("rnd idle ready", 32'({req1_ready, req0_ready}), 0);
                if (rv[0] || rv[1]) waitc++;
                else waitc = 0;
                chk("rnd grant wait bound", 32'(waitc <= 3), 1);
            end
            mem_ready = act && (cnt + 1 == dly);
            mem_rdata = (mem_ready && !twr) ? ref_mem[taddr] : W'($urandom);
            for (int r = 0; r < 2; r++) begin
                if (rhold[r]) begin
                    rhold[r] = 0;
                    rnew[r]  = 1;
                end else if (rnew[r] || !rv[r]) begin
                    rnew[r] = 0;
                    rv[r]   = ($urandom_range(0, 1) == 1);
                    rw[r]   = ($urandom_range(0, 1) == 1);
                    ra[r]   = AW'($urandom);
                    rdd[r]  = W'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
